// File: rtl/fir4_seq_sched_pkg.sv
// Shared definitions for the fir4 filter family.
package fir4_pkg;

    typedef enum logic [1:0] {IDLE, ACC, HOLD} fir4_state_t;

    localparam int unsigned TAPS = 4;

endpackage

// File: rtl/fir4_seq_sched_if.sv
// Streaming handshake bundle for fir4_seq_sched: input sample, output sum, busy flag.
interface fir4_seq_sched_if #(
    parameter int unsigned W = 16
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic         out_valid;
    logic         out_ready;
    logic [W+1:0] s;
    logic         busy;

    modport master (
        output in_valid, a, out_ready,
        input  in_ready, out_valid, s, busy
    );

    modport slave (
        input  in_valid, a, out_ready,
        output in_ready, out_valid, s, busy
    );
endinterface

// File: rtl/fir4_seq_sched_tap_line.sv
// Four-entry sample history with shift enable and a read-select mux for the shared adder.
module fir4_tap_line
    import fir4_pkg::*;
#(
    parameter int unsigned w = 16
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    shift_i,
    input  logic [w-1:0]            d_i,
    input  logic [$clog2(TAPS)-1:0] sel_i,
    output logic [w-1:0]            q_o
);
    logic [w-1:0] tap_q [TAPS];

    always_ff @(posedge clk) begin
        if (rst_i) begin
            tap_q <= '{default: '0};
        end else if (shift_i) begin
            tap_q[0] <= d_i;
            for (int unsigned i = 1; i < TAPS; i++) begin
                tap_q[i] <= tap_q[i-1];
            end
        end
    end

    assign q_o = tap_q[sel_i];
endmodule

// File: rtl/fir4_seq_sched.sv
// Sequential 4-tap unity FIR: one shared adder walks the taps over four cycles,
// with valid/ready handshakes on both sides.
module fir4_seq_sched
    import fir4_pkg::*;
#(
    parameter int unsigned w = 16
) (
    input  logic              clk,
    input  logic              reset,
    fir4_seq_sched_if.slave   bus
);
    fir4_state_t               state_q, state_d;
    logic [$clog2(TAPS)-1:0]   cnt_q, cnt_d;
    logic [w+1:0]              acc_q, acc_d;
    logic [w+1:0]              s_q, s_d;
    logic [w+1:0]              sum;
    logic [w-1:0]              tap_rd;
    logic                      accept;

    fir4_tap_line #(.w(w)) u_taps (
        .clk     (clk),
        .rst_i   (reset),
        .shift_i (accept),
        .d_i     (bus.a),
        .sel_i   (cnt_q),
        .q_o     (tap_rd)
    );

    // HOLD passes out_ready through so a consume and a new accept share one edge.
    assign bus.in_ready = !reset && ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
    assign accept       = bus.in_valid && bus.in_ready;
    assign sum          = acc_q + {2'b00, tap_rd};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        s_d     = s_q;
        case (state_q)
            IDLE: ;
            ACC: begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ($clog2(TAPS))'(TAPS - 1)) begin
                    s_d     = sum;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
        end
    end

    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.s         = s_q;
endmodule

// File: tb/tb_fir4_seq_sched.sv
// Scoreboard bench for fir4_seq_sched: directed scenarios plus a randomized phase.
module tb_fir4_seq_sched;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic reset;

    fir4_seq_sched_if #(.W(W)) bus ();

    fir4_seq_sched #(.w(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input bit ok, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: history of the last four accepted samples, zeros after reset.
    longint      hist [4];
    longint      exp_q [$];
    int          lat_q [$];
    int          cyc = 0;
    int          last_acc = -100;
    bit          ov_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) hist[i] = 0;
            exp_q.delete();
            lat_q.delete();
            last_acc = -100;
            ov_prev  = 0;
        end else begin
            if (bus.out_valid && !ov_prev) begin
                if (lat_q.size() == 0) check("latency_no_accept", 1'b0, cyc, 0);
                else begin
                    int k;
                    k = lat_q.pop_front();
                    check("latency", (cyc - k) == 4, cyc - k, 4);
                end
            end
            if (cyc >= last_acc && cyc - last_acc <= 3) begin
                check("in_ready_low_in_acc", bus.in_ready == 1'b0, bus.in_ready, 0);
                check("busy_in_acc", bus.busy == 1'b1, bus.busy, 1);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_output", 1'b0, bus.s, 0);
                else begin
                    longint e;
                    e = exp_q.pop_front();
                    check("result", longint'(bus.s) == e, bus.s, e);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = longint'(bus.a);
                exp_q.push_back(hist[0] + hist[1] + hist[2] + hist[3]);
                lat_q.push_back(cyc + 1);
                last_acc = cyc + 1;
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] val);
        bit got;
        got = 0;
        bus.in_valid = 1'b1;
        bus.a        = val;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
        end
        if (!got) check("send_timeout", 1'b0, 0, 1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_ov(output logic [W+1:0] sv);
        bit got;
        got = 0;
        sv  = '0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                got = 1;
                sv  = bus.s;
            end
        end
        if (!got) check("out_valid_timeout", 1'b0, 0, 1);
        step();
    endtask

    initial begin
        logic [W+1:0] sv;
        logic [W+1:0] held;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", bus.in_ready == 1'b0, bus.in_ready, 0);
        check("reset_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
        check("reset_busy", bus.busy == 1'b0, bus.busy, 0);
        check("reset_s", bus.s == '0, bus.s, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready == 1'b1, bus.in_ready, 1);
        step();

        // 1: ramp 1..4
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(W'(i));
        wait_ov(sv);
        check("ramp_last", sv == 18'd10, sv, 10);
        repeat (2) step();

        // 2: full-scale samples
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        wait_ov(sv);
        check("full_scale", sv == 18'h3FFFC, sv, 18'h3FFFC);
        repeat (2) step();

        // 3: output stall with input pressure
        bus.out_ready = 1'b0;
        send(16'd9);
        wait_ov(held);
        bus.in_valid = 1'b1;
        bus.a        = 16'd21;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_out_valid", bus.out_valid == 1'b1, bus.out_valid, 1);
            check("stall_s", bus.s == held, bus.s, held);
            check("stall_in_ready", bus.in_ready == 1'b0, bus.in_ready, 0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        wait_ov(sv);
        repeat (2) step();

        // 4: consume and accept on the same edge
        bus.out_ready = 1'b0;
        send(16'd2);
        wait_ov(sv);
        bus.in_valid  = 1'b1;
        bus.a         = 16'd5;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("hold_in_ready", bus.in_ready == 1'b1, bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("no_idle_busy", bus.busy == 1'b1, bus.busy, 1);
        check("no_idle_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
        step();
        wait_ov(sv);
        repeat (2) step();

        // 5: reset during accumulation
        send(16'd3);
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", bus.out_valid == 1'b0, bus.out_valid, 0);
        check("abort_busy", bus.busy == 1'b0, bus.busy, 0);
        step();
        send(16'd7);
        wait_ov(sv);
        check("after_abort", sv == 18'd7, sv, 7);
        repeat (2) step();

        // 6: in_valid toggling while busy must be ignored
        send(16'd10);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = ~bus.in_valid;
            bus.a        = W'($urandom);
            step();
        end
        bus.in_valid = 1'b0;
        wait_ov(sv);
        repeat (2) step();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.a         = W'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("drain_empty", exp_q.size() == 0, exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
